// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and forwarding selects.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand forwarding source select for one decode-stage source register.
// The EX/M slot holds the younger result, so it wins over M/WB.
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  src_used_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_wen_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_wen_i,
    output fwd_sel_e              sel_o
);

    logic src_live;

    assign src_live = src_used_i && (src_i != '0);

    // Pick the youngest in-flight producer of this source; register 0 never forwards.
    always_comb begin
        sel_o = FWD_RF;
        if (src_live && mem_wen_i && (mem_rd_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (src_live && wb_wen_i && (wb_rd_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Backward-direction hazard controller: load-use stalls, taken-branch flushes,
// data-memory wait freezes and operand forwarding selects.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  n_reset_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_rs_used_i,
    input  logic                  id_rt_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_wen_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_wen_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_wen_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  mem_busy_i,
    output logic                  stall_pc_o,
    output logic                  stall_if_id_o,
    output logic                  bubble_o,
    output logic                  flush_if_id_o,
    output logic                  stall_all_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic [1:0]            state_o
);

    localparam int               CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hazard_state_e    state_q, state_d, eval_state;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             ret_state_q, ret_state_d;   // 1 = resume FLUSH, 0 = resume RUN
    logic             lu;
    logic             stall_pc, stall_if_id, bubble, flush_if_id, stall_all;
    fwd_sel_e         fwd_a, fwd_b;

    assign lu = ex_is_load_i && ex_wen_i && (ex_rd_i != '0) &&
                ((id_rs_used_i && (id_rs_i == ex_rd_i)) ||
                 (id_rt_used_i && (id_rt_i == ex_rd_i)));

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_i(id_rs_i), .src_used_i(id_rs_used_i),
        .mem_rd_i(mem_rd_i), .mem_wen_i(mem_wen_i),
        .wb_rd_i(wb_rd_i), .wb_wen_i(wb_wen_i),
        .sel_o(fwd_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_i(id_rt_i), .src_used_i(id_rt_used_i),
        .mem_rd_i(mem_rd_i), .mem_wen_i(mem_wen_i),
        .wb_rd_i(wb_rd_i), .wb_wen_i(wb_wen_i),
        .sel_o(fwd_b)
    );

    // Leaving MEM_WAIT behaves exactly like the saved state in that same cycle.
    always_comb begin
        eval_state = state_q;
        case (state_q)
            RUN, FLUSH: eval_state = state_q;
            MEM_WAIT:   if (!mem_busy_i) eval_state = ret_state_q ? FLUSH : RUN;
            default:    eval_state = RUN;
        endcase
    end

    // Next state, flush counter and upstream control, prioritised busy > branch > load-use.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ret_state_d = ret_state_q;
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        bubble      = 1'b0;
        flush_if_id = 1'b0;
        stall_all   = 1'b0;
        case (eval_state)
            RUN: begin
                state_d = RUN;
                if (mem_busy_i) begin
                    stall_all   = 1'b1;
                    state_d     = MEM_WAIT;
                    ret_state_d = 1'b0;
                end else if (ex_branch_taken_i) begin
                    flush_if_id = 1'b1;
                    bubble      = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = CNT_LOAD;
                    end
                end else if (lu) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    bubble      = 1'b1;
                end
            end
            FLUSH: begin
                if (mem_busy_i) begin
                    stall_all   = 1'b1;
                    state_d     = MEM_WAIT;
                    ret_state_d = 1'b1;
                end else begin
                    flush_if_id = 1'b1;
                    bubble      = 1'b1;
                    flush_cnt_d = flush_cnt_q - CNT_ONE;
                    state_d     = (flush_cnt_q <= CNT_ONE) ? RUN : FLUSH;
                end
            end
            default: begin
                stall_all = 1'b1;
                state_d   = MEM_WAIT;
            end
        endcase
    end

    // State, flush counter and return-state registers.
    always_ff @(posedge clk) begin
        if (!n_reset_i) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            ret_state_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ret_state_q <= ret_state_d;
        end
    end

    // All outputs are held quiet while reset is asserted.
    always_comb begin
        stall_pc_o    = n_reset_i & stall_pc;
        stall_if_id_o = n_reset_i & stall_if_id;
        bubble_o      = n_reset_i & bubble;
        flush_if_id_o = n_reset_i & flush_if_id;
        stall_all_o   = n_reset_i & stall_all;
        fwd_a_o       = n_reset_i ? fwd_a   : FWD_RF;
        fwd_b_o       = n_reset_i ? fwd_b   : FWD_RF;
        state_o       = n_reset_i ? state_q : 2'd0;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: scenario tasks push the expected output
// vector per cycle, a negedge scoreboard pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam int W = 11;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_FL  = 2'd1;
    localparam logic [1:0] S_MW  = 2'd2;

    logic       clk;
    logic       n_reset;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       id_rs_used, id_rt_used, ex_wen, ex_is_load, mem_wen, wb_wen;
    logic       branch, busy;

    logic       stall_pc, stall_if_id, bubble, flush_if_id, stall_all;
    logic [1:0] fwd_a, fwd_b, state;
    logic       stall_pc_1, stall_if_id_1, bubble_1, flush_if_id_1, stall_all_1;
    logic [1:0] fwd_a_1, fwd_b_1, state_1;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc_no = 0;
    string        tag = "none";

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .n_reset_i(n_reset),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .ex_rd_i(ex_rd), .ex_wen_i(ex_wen), .ex_is_load_i(ex_is_load),
        .mem_rd_i(mem_rd), .mem_wen_i(mem_wen), .wb_rd_i(wb_rd), .wb_wen_i(wb_wen),
        .ex_branch_taken_i(branch), .mem_busy_i(busy),
        .stall_pc_o(stall_pc), .stall_if_id_o(stall_if_id), .bubble_o(bubble),
        .flush_if_id_o(flush_if_id), .stall_all_o(stall_all),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .state_o(state)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .n_reset_i(n_reset),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .ex_rd_i(ex_rd), .ex_wen_i(ex_wen), .ex_is_load_i(ex_is_load),
        .mem_rd_i(mem_rd), .mem_wen_i(mem_wen), .wb_rd_i(wb_rd), .wb_wen_i(wb_wen),
        .ex_branch_taken_i(branch), .mem_busy_i(busy),
        .stall_pc_o(stall_pc_1), .stall_if_id_o(stall_if_id_1), .bubble_o(bubble_1),
        .flush_if_id_o(flush_if_id_1), .stall_all_o(stall_all_1),
        .fwd_a_o(fwd_a_1), .fwd_b_o(fwd_b_1), .state_o(state_1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {stall_pc, stall_if_id, bubble, flush, stall_all, fwd_a, fwd_b, state}
    function automatic logic [W-1:0] ev(input logic spc, input logic sif, input logic bub,
                                        input logic fl, input logic sa, input logic [1:0] fa,
                                        input logic [1:0] fb, input logic [1:0] st);
        return {spc, sif, bub, fl, sa, fa, fb, st};
    endfunction

    function automatic logic [W-1:0] e_idle(input logic [1:0] st);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, st);
    endfunction

    function automatic logic [W-1:0] e_flush(input logic [1:0] st);
        return ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, st);
    endfunction

    function automatic logic [W-1:0] e_freeze(input logic [1:0] st);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, st);
    endfunction

    // Scoreboard: compare DUT outputs against the oldest expected vector.
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] want;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            act  = {stall_pc, stall_if_id, bubble, flush_if_id, stall_all, fwd_a, fwd_b, state};
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL %s cyc%0d: got %b required %b (spc,sif,bub,fl,sa,fa,fb,st)",
                         tag, cyc_no, act, want);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic cyc(input logic [W-1:0] e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        ex_rd = '0; ex_wen = 1'b0; ex_is_load = 1'b0;
        mem_rd = '0; mem_wen = 1'b0; wb_rd = '0; wb_wen = 1'b0;
        branch = 1'b0; busy = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = r; id_rs = r; id_rs_used = 1'b1;
    endtask

    task automatic test_reset();
        tag = "reset";
        tick();
        set_lu(5'd5); branch = 1'b1; mem_wen = 1'b1; mem_rd = 5'd3; id_rt = 5'd3; id_rt_used = 1'b1;
        cyc(e_idle(S_RUN));
        if ({stall_pc_1, bubble_1, flush_if_id_1, stall_all_1, fwd_b_1, state_1} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_dut1: got %b required 0",
                     {stall_pc_1, bubble_1, flush_if_id_1, stall_all_1, fwd_b_1, state_1});
        end
        n_cmp++;
        tick(); busy = 1'b1;
        cyc(e_idle(S_RUN));
        tick(); clear_inputs(); n_reset = 1'b1;
        cyc(e_idle(S_RUN));
    endtask

    task automatic test_load_use();
        tag = "load_use";
        tick(); set_lu(5'd5);
        cyc(ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, S_RUN));
        tick(); ex_is_load = 1'b0; ex_wen = 1'b0; ex_rd = '0;
        cyc(e_idle(S_RUN));
        tag = "load_use_rt";
        tick(); clear_inputs(); ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd9;
        id_rt = 5'd9; id_rt_used = 1'b1; id_rs = 5'd4; id_rs_used = 1'b1;
        cyc(ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, S_RUN));
        tag = "load_use_rd0";
        tick(); clear_inputs(); set_lu(5'd0);
        cyc(e_idle(S_RUN));
        tag = "load_use_unused";
        tick(); set_lu(5'd6); id_rs_used = 1'b0;
        cyc(e_idle(S_RUN));
        tag = "load_use_nowen";
        tick(); set_lu(5'd6); ex_wen = 1'b0;
        cyc(e_idle(S_RUN));
        tag = "load_use_notload";
        tick(); set_lu(5'd6); ex_is_load = 1'b0;
        cyc(e_idle(S_RUN));
        tick(); clear_inputs();
        cyc(e_idle(S_RUN));
    endtask

    task automatic test_branch();
        tag = "branch";
        tick(); branch = 1'b1;
        cyc(e_flush(S_RUN));
        if (flush_if_id_1 !== 1'b1 || state_1 !== S_RUN) begin
            n_err++;
            $display("FAIL branch_fc1_first: got fl=%b st=%0d required fl=1 st=0", flush_if_id_1, state_1);
        end
        n_cmp++;
        // Load-use present during FLUSH must be ignored by the 2-cycle flush instance.
        tick(); branch = 1'b0; set_lu(5'd7);
        cyc(e_flush(S_FL));
        if (flush_if_id_1 !== 1'b0 || state_1 !== S_RUN || stall_pc_1 !== 1'b1) begin
            n_err++;
            $display("FAIL branch_fc1_second: got fl=%b st=%0d spc=%b required fl=0 st=0 spc=1",
                     flush_if_id_1, state_1, stall_pc_1);
        end
        n_cmp++;
        tick(); clear_inputs();
        cyc(e_idle(S_RUN));
    endtask

    task automatic test_flush_mem_wait();
        tag = "flush_mem_wait";
        tick(); branch = 1'b1;
        cyc(e_flush(S_RUN));
        tick(); branch = 1'b0; busy = 1'b1;
        cyc(e_freeze(S_FL));
        tick();
        cyc(e_freeze(S_MW));
        tick();
        cyc(e_freeze(S_MW));
        tick(); busy = 1'b0;
        cyc(e_flush(S_MW));
        tick();
        cyc(e_idle(S_RUN));
        tick();
        cyc(e_idle(S_RUN));
    endtask

    task automatic test_busy_and_branch();
        tag = "busy_and_branch";
        tick(); busy = 1'b1; branch = 1'b1;
        cyc(e_freeze(S_RUN));
        tick();
        cyc(e_freeze(S_MW));
        tick(); busy = 1'b0;
        cyc(e_flush(S_MW));
        tick(); branch = 1'b0;
        cyc(e_flush(S_FL));
        tick();
        cyc(e_idle(S_RUN));
    endtask

    task automatic test_forwarding();
        logic [1:0] fa, fb;
        tag = "fwd_mem_over_wb";
        tick(); clear_inputs();
        mem_wen = 1'b1; mem_rd = 5'd7; wb_wen = 1'b1; wb_rd = 5'd7;
        id_rt = 5'd7; id_rt_used = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1;
        cyc(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, S_RUN));
        tag = "fwd_wb";
        tick(); mem_wen = 1'b0;
        cyc(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, S_RUN));
        tag = "fwd_rd0";
        tick(); mem_wen = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; id_rt = 5'd0;
        cyc(e_idle(S_RUN));
        tag = "fwd_unused";
        tick(); mem_rd = 5'd4; id_rs = 5'd4; id_rs_used = 1'b0; id_rt = 5'd4; id_rt_used = 1'b1;
        cyc(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, S_RUN));
        // Forwarding stays live while flushing.
        tag = "fwd_in_flush";
        tick(); branch = 1'b1; id_rs_used = 1'b1;
        cyc(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1, S_RUN));
        tick(); branch = 1'b0; mem_wen = 1'b0; wb_rd = 5'd4;
        cyc(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2, S_FL));
        tag = "fwd_random";
        for (int i = 0; i < 12; i++) begin
            tick(); clear_inputs();
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_rs_used = 1'($urandom_range(0, 1)); id_rt_used = 1'($urandom_range(0, 1));
            mem_rd = 5'($urandom_range(0, 3)); mem_wen = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 3)); wb_wen = 1'($urandom_range(0, 1));
            fa = 2'd0;
            if (id_rs_used && id_rs != 0 && mem_wen && mem_rd == id_rs) fa = 2'd1;
            else if (id_rs_used && id_rs != 0 && wb_wen && wb_rd == id_rs) fa = 2'd2;
            fb = 2'd0;
            if (id_rt_used && id_rt != 0 && mem_wen && mem_rd == id_rt) fb = 2'd1;
            else if (id_rt_used && id_rt != 0 && wb_wen && wb_rd == id_rt) fb = 2'd2;
            cyc(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fa, fb, S_RUN));
        end
        tick(); clear_inputs();
        cyc(e_idle(S_RUN));
    endtask

    task automatic test_reset_mid_flush();
        tag = "reset_mid_flush";
        tick(); branch = 1'b1;
        cyc(e_flush(S_RUN));
        tick(); branch = 1'b0; n_reset = 1'b0;
        cyc(e_idle(S_RUN));
        tick(); n_reset = 1'b1;
        cyc(e_idle(S_RUN));
        tick();
        cyc(e_idle(S_RUN));
        tag = "reset_mid_mem_wait";
        tick(); busy = 1'b1;
        cyc(e_freeze(S_RUN));
        tick();
        cyc(e_freeze(S_MW));
        tick(); n_reset = 1'b0;
        cyc(e_idle(S_RUN));
        tick(); n_reset = 1'b1; busy = 1'b0;
        cyc(e_idle(S_RUN));
    endtask

    task automatic test_back_to_back();
        tag = "back_to_back_lu";
        tick(); set_lu(5'd8);
        cyc(ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, S_RUN));
        tick(); clear_inputs(); set_lu(5'd9);
        cyc(ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, S_RUN));
        tag = "back_to_back_branch";
        tick(); clear_inputs(); branch = 1'b1;
        cyc(e_flush(S_RUN));
        tick(); branch = 1'b0;
        cyc(e_flush(S_FL));
        tick(); branch = 1'b1;
        cyc(e_flush(S_RUN));
        tick(); branch = 1'b0;
        cyc(e_flush(S_FL));
        tick();
        cyc(e_idle(S_RUN));
    endtask

    initial begin
        n_reset = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_flush_mem_wait();
        test_busy_and_branch();
        test_forwarding();
        test_reset_mid_flush();
        test_back_to_back();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Backward-direction pipeline controller: consumes destination/write-enable state of the ID/EX, EX/M and M/WB control slots and the decode stage's source registers, and drives stall, bubble, flush and forwarding signals back upstream. Sits beside the forward-flowing control-slot pipeline. It gates the fetch/decode registers, and zeroes the new control bundle entering ID/EX when a bubble is required. Handles load-use stalls, taken-branch flushes and data-memory wait freezes.

## Interface
- REG_ADDR_W, 5, register-address width
- FLUSH_CYCLES, 2, total cycles flush_if_id_o/bubble_o stay high per taken branch (>= 1)

- clk  in  1  pipeline clock
- n_reset_i  in  1  synchronous, active-low reset
- id_rs_i, id_rt_i  in  REG_ADDR_W  decode-stage source registers
- id_rs_used_i, id_rt_used_i  in  1  source actually read
- ex_rd_i, ex_wen_i, ex_is_load_i  in  REG_ADDR_W/1/1  ID/EX slot destination, write enable, load flag
- mem_rd_i, mem_wen_i  in  REG_ADDR_W/1  EX/M slot destination, write enable
- wb_rd_i, wb_wen_i  in  REG_ADDR_W/1  M/WB slot destination, write enable
- ex_branch_taken_i  in  1  branch resolved taken in EX
- mem_busy_i  in  1  data memory cannot complete this cycle
- stall_pc_o, stall_if_id_o  out  1  hold PC / IF-ID register
- bubble_o  out  1  replace the new control bundle with all-zero (nop)
- flush_if_id_o  out  1  clear IF-ID register
- stall_all_o  out  1  freeze every pipeline register, including control slots
- fwd_a_o, fwd_b_o  out  2  operand source: 00 regfile, 01 EX/M, 10 M/WB
- state_o  out  2  current FSM state (debug)

## Operation
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2; encoding 3 unused and returns to RUN.
- Down-counter flush_cnt, width $clog2(FLUSH_CYCLES+1); saved-state register ret_state (1 bit: RUN/FLUSH).
- Load-use hazard (lu) = ex_is_load_i & ex_wen_i & ex_rd_i != 0 & ((id_rs_used_i & id_rs_i == ex_rd_i) | (id_rt_used_i & id_rt_i == ex_rd_i)).
- Priority in RUN: mem_busy_i > ex_branch_taken_i > lu.
  - mem_busy_i: stall_all_o=1. Next state MEM_WAIT, ret_state=RUN.
  - taken branch: flush_if_id_o=1, bubble_o=1. If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1 and stay there until flush_cnt reaches 0.
  - lu: stall_pc_o=1, stall_if_id_o=1, bubble_o=1 for the detection cycle only. State stays RUN; the nop in ID/EX removes the hazard next cycle.
- FLUSH: flush_if_id_o=1, bubble_o=1, flush_cnt decrements. When flush_cnt reaches 1 and decrements, next state is RUN. lu is ignored (the decode slot is being flushed). mem_busy_i has priority: stall_all_o=1, next MEM_WAIT, ret_state=FLUSH, flush_cnt held.
- MEM_WAIT: stall_all_o=1 while mem_busy_i=1; all other stall/flush/bubble outputs are 0. On the first cycle mem_busy_i=0, return to ret_state with outputs evaluated as in that state.
  - ex_branch_taken_i seen during the freeze is not lost: the EX slot is held and the branch is re-evaluated after exit.
- Forwarding is combinational and active in every state. For each operand:
  - select 01 if mem_wen_i and mem_rd_i == src != 0 and the source is used;
  - else 10 if the same holds for wb;
  - else 00.
  - EX/M wins when both match.

## Timing
- Stall, bubble and flush outputs are combinational from state plus current inputs: 0-cycle reaction to hazards.
- State, flush_cnt and ret_state are registered on posedge clk.
- Reset: while n_reset_i=0, all outputs are forced to 0 and fwd_*=00. At the clock edge, state=RUN, flush_cnt=0, ret_state=RUN.
- Reset mid-FLUSH or mid-MEM_WAIT aborts immediately, with no residual flush.
- Taken branch: exactly FLUSH_CYCLES consecutive flush cycles, plus any interleaved MEM_WAIT cycles, which do not count.
- Load-use: exactly one stall cycle per hazard.

## Structure
- Shared definitions package: hazard_state_e (RUN/FLUSH/MEM_WAIT), fwd_sel_e (FWD_RF/FWD_MEM/FWD_WB).
- One sub-module, fwd_select: purely combinational comparator producing fwd_sel_e for one operand, instantiated twice.
- FSM, counter and priority logic live in pipeline_hazard_ctrl.

## Test plan
- ex_is_load_i=1, ex_wen_i=1, ex_rd_i=5, id_rs_i=5, id_rs_used_i=1 -> one cycle of stall_pc_o=stall_if_id_o=bubble_o=1; with ex_rd_i=0 -> no stall.
- ex_branch_taken_i pulse, FLUSH_CYCLES=2 -> flush_if_id_o=bubble_o=1 for 2 cycles, state_o 0→1→0; with FLUSH_CYCLES=1 state_o stays 0.
- Branch taken, mem_busy_i high for 3 cycles during FLUSH -> flush cycle, 3 stall_all_o cycles, remaining flush cycle, RUN.
- mem_busy_i and ex_branch_taken_i high together -> stall_all_o only until busy drops, then the flush sequence starts.
- mem_wen_i=1, mem_rd_i=7, wb_wen_i=1, wb_rd_i=7, id_rt_i=7, id_rt_used_i=1 -> fwd_b_o=01; clear mem_wen_i -> 10; rd=0 -> 00.
- n_reset_i=0 asserted mid-FLUSH -> all outputs 0 that cycle; after release, state_o=0 and no flush.
